// File: rtl/lu_pkg.sv
// Shared definitions for the bit-serial logic controller and the 1-bit logic slice.
package lu_pkg;

    typedef enum logic [2:0] {
        LU_AND = 3'b000,
        LU_OR  = 3'b001,
        LU_XOR = 3'b010,
        LU_NOT = 3'b011,
        LU_SHL = 3'b100
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Codes above LU_SHL have no slice operation behind them.
    function automatic logic op_legal(input op_t op);
        return 3'(op) <= 3'(LU_SHL);
    endfunction

endpackage

// File: rtl/lu_bitcnt.sv
// Bit-index counter with synchronous clear/enable and a terminal-count flag.
module lu_bitcnt #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     en,
    output logic [$clog2(WIDTH)-1:0] count,
    output logic                     last
);

    localparam int unsigned CNTW = $clog2(WIDTH);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNTW'(1);
        end
    end

    assign last = (count == CNTW'(WIDTH - 1));

endmodule

// File: rtl/bitserial_logic_ctrl.sv
// Sequences WIDTH-bit logic ops through an external 1-bit slice, LSB first,
// with valid/ready handshakes on the command and result sides.
module bitserial_logic_ctrl
    import lu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             slice_a,
    output logic             slice_b,
    output logic [2:0]       slice_opsel,
    output logic             slice_cin,
    input  logic             slice_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err,
    output logic             busy
);

    localparam int unsigned CNTW = $clog2(WIDTH);

    state_t            state_q;
    state_t            state_d;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    op_t               op_q;
    logic [CNTW-1:0]   cnt;
    logic [CNTW-1:0]   cnt_nxt;
    logic              cnt_last;
    logic              cnt_clr;
    logic              cnt_en;
    logic              accept;
    logic              in_legal;
    logic              slice_a_d;
    logic              slice_b_d;
    logic [2:0]        slice_opsel_d;
    logic              slice_cin_d;

    lu_bitcnt #(.WIDTH(WIDTH)) u_bitcnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (cnt),
        .last  (cnt_last)
    );

    assign accept   = in_valid && in_ready;
    assign in_legal = op_legal(op_t'(in_op));
    assign cnt_nxt  = cnt + CNTW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the slice drive for the cycle after this edge.
    always_comb begin
        state_d       = state_q;
        cnt_clr       = 1'b0;
        cnt_en        = 1'b0;
        slice_a_d     = 1'b0;
        slice_b_d     = 1'b0;
        slice_opsel_d = 3'b000;
        slice_cin_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_clr = 1'b1;
                    if (in_legal) begin
                        state_d       = S_RUN;
                        slice_a_d     = in_a[0];
                        slice_b_d     = in_b[0];
                        slice_opsel_d = in_op;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (cnt_last) begin
                    state_d = S_DONE;
                end else begin
                    cnt_en        = 1'b1;
                    slice_a_d     = a_q[cnt_nxt];
                    slice_b_d     = b_q[cnt_nxt];
                    slice_opsel_d = 3'(op_q);
                    // SHL feeds the previous a bit through the slice's carry path.
                    slice_cin_d   = (op_q == LU_SHL) ? a_q[cnt] : 1'b0;
                end
            end
            S_DONE: begin
                if (res_valid && res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready    <= 1'b1;
            busy        <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_err     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= LU_AND;
            slice_a     <= 1'b0;
            slice_b     <= 1'b0;
            slice_opsel <= 3'b000;
            slice_cin   <= 1'b0;
        end else begin
            in_ready    <= (state_d == S_IDLE);
            busy        <= (state_d == S_RUN);
            res_valid   <= (state_d == S_DONE);
            slice_a     <= slice_a_d;
            slice_b     <= slice_b_d;
            slice_opsel <= slice_opsel_d;
            slice_cin   <= slice_cin_d;
            if (state_q == S_IDLE && accept) begin
                a_q      <= in_a;
                b_q      <= in_b;
                op_q     <= op_t'(in_op);
                res_data <= '0;
                res_err  <= !in_legal;
            end else if (state_q == S_RUN) begin
                res_data[cnt] <= slice_out;
            end
        end
    end

endmodule

// File: tb/tb_bitserial_logic_ctrl.sv
// Directed, table-driven bench for bitserial_logic_ctrl with a behavioural 1-bit slice.
module tb_bitserial_logic_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             slice_a;
    logic             slice_b;
    logic [2:0]       slice_opsel;
    logic             slice_cin;
    logic             slice_out;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_err;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bitserial_logic_ctrl #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .slice_a     (slice_a),
        .slice_b     (slice_b),
        .slice_opsel (slice_opsel),
        .slice_cin   (slice_cin),
        .slice_out   (slice_out),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_err     (res_err),
        .busy        (busy)
    );

    // Behavioural model of the shared 1-bit logic slice.
    always_comb begin
        case (slice_opsel)
            3'b000:  slice_out = slice_a & slice_b;
            3'b001:  slice_out = slice_a | slice_b;
            3'b010:  slice_out = slice_a ^ slice_b;
            3'b011:  slice_out = ~slice_a;
            3'b100:  slice_out = slice_cin;
            default: slice_out = 1'b0;
        endcase
    end

    typedef struct {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp_data;
        logic             exp_err;
        string            name;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one command, check latency/busy/slice activity, then check the result.
    // Leaves the DUT in DONE with res_ready=0 when hold is set.
    task automatic issue(input vec_t v, input bit hold);
        int n;
        bit legal;
        legal = (v.op <= 3'b100);
        @(negedge clk);
        chk({v.name, " in_ready before"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_op     = v.op;
        in_a      = v.a;
        in_b      = v.b;
        res_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = ~v.a;
        in_b     = ~v.b;
        in_op    = 3'b111;
        n = 1;
        while (!res_valid && n < 40) begin
            if (legal && n <= WIDTH) begin
                if (busy !== 1'b1) chk({v.name, " busy"}, 32'(busy), 32'd1);
                if (in_ready !== 1'b0) chk({v.name, " in_ready run"}, 32'(in_ready), 32'd0);
            end
            if (v.op == 3'b100 && n == 1) chk({v.name, " cin k0"}, 32'(slice_cin), 32'd0);
            if (v.op == 3'b100 && n == 2) chk({v.name, " cin k1"}, 32'(slice_cin), 32'(v.a[0]));
            @(negedge clk);
            n++;
        end
        chk({v.name, " latency"}, 32'(n), legal ? 32'(WIDTH + 1) : 32'd1);
        chk({v.name, " data"}, 32'(res_data), 32'(v.exp_data));
        chk({v.name, " err"}, 32'(res_err), 32'(v.exp_err));
        chk({v.name, " busy done"}, 32'(busy), 32'd0);
        chk({v.name, " slice idle"}, 32'({slice_a, slice_b, slice_opsel, slice_cin}), 32'd0);
        if (!hold) begin
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            chk({v.name, " in_ready after"}, 32'(in_ready), 32'd1);
            chk({v.name, " valid after"}, 32'(res_valid), 32'd0);
        end
    endtask

    initial begin
        vecs[0] = '{op: 3'b000, a: 8'hF0, b: 8'h3C, exp_data: 8'h30, exp_err: 1'b0, name: "and"};
        vecs[1] = '{op: 3'b010, a: 8'hAA, b: 8'hFF, exp_data: 8'h55, exp_err: 1'b0, name: "xor"};
        vecs[2] = '{op: 3'b011, a: 8'h0F, b: 8'h5A, exp_data: 8'hF0, exp_err: 1'b0, name: "not"};
        vecs[3] = '{op: 3'b001, a: 8'h81, b: 8'h18, exp_data: 8'h99, exp_err: 1'b0, name: "or"};
        vecs[4] = '{op: 3'b100, a: 8'h81, b: 8'h00, exp_data: 8'h02, exp_err: 1'b0, name: "shl81"};
        vecs[5] = '{op: 3'b100, a: 8'h7F, b: 8'hFF, exp_data: 8'hFE, exp_err: 1'b0, name: "shl7f"};
        vecs[6] = '{op: 3'b110, a: 8'hFF, b: 8'hFF, exp_data: 8'h00, exp_err: 1'b1, name: "illegal"};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op     = 3'b000;
        in_a      = '0;
        in_b      = '0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst res_valid", 32'(res_valid), 32'd0);
        chk("rst res_data", 32'(res_data), 32'd0);
        chk("rst res_err", 32'(res_err), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst slice", 32'({slice_a, slice_b, slice_opsel, slice_cin}), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) issue(vecs[i], 1'b0);

        // Backpressure: result held while a competing command is offered.
        issue(vecs[0], 1'b1);
        in_valid = 1'b1;
        in_op    = 3'b010;
        in_a     = 8'h12;
        in_b     = 8'h34;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp res_valid", 32'(res_valid), 32'd1);
            chk("bp res_data", 32'(res_data), 32'h30);
            chk("bp in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("bp in_ready after", 32'(in_ready), 32'd1);
        chk("bp valid after", 32'(res_valid), 32'd0);
        chk("bp busy after", 32'(busy), 32'd0);

        // Reset in RUN at k=3 discards the command.
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 3'b010;
        in_a     = 8'hAA;
        in_b     = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid k3 busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid in_ready", 32'(in_ready), 32'd1);
        chk("mid res_valid", 32'(res_valid), 32'd0);
        chk("mid busy", 32'(busy), 32'd0);
        chk("mid slice", 32'({slice_a, slice_b, slice_opsel, slice_cin}), 32'd0);
        chk("mid res_data", 32'(res_data), 32'd0);
        res_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (res_valid !== 1'b0 || busy !== 1'b0) chk("mid stale", 32'({res_valid, busy}), 32'd0);
        end
        chk("mid quiet", 32'({res_valid, busy, in_ready}), 32'd1);
        res_ready = 1'b0;

        issue(vecs[3], 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bitserial_logic_ctrl.md
Name: bitserial_logic_ctrl

Overview:
Sequencer that performs WIDTH-bit logic operations on an external 1-bit logic slice, one bit per cycle, LSB first. It accepts a command (op, a, b) over a valid/ready handshake and drives the slice's a/b/opsel/cin inputs each cycle. It collects the slice output into a result register and presents the word over a second valid/ready handshake. It sits between the instruction-decode logic and the shared 1-bit logic slice.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.
CNTW, $clog2(WIDTH), bit-index counter width; derived, not overridden.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  command valid
in_ready  out  1  controller can accept a command
in_op  in  3  operation code (see Behaviour)
in_a  in  WIDTH  operand a
in_b  in  WIDTH  operand b
slice_a  out  1  bit of a driven to slice
slice_b  out  1  bit of b driven to slice
slice_opsel  out  3  operation select to slice
slice_cin  out  1  carry/pass input to slice
slice_out  in  1  combinational slice result bit
res_valid  out  1  result valid
res_ready  in  1  consumer accepts result
res_data  out  WIDTH  result word
res_err  out  1  illegal op flag, qualified by res_valid
busy  out  1  high in RUN

Behaviour:
- Op codes:
  - 000 AND, 001 OR, 010 XOR, 011 NOT a, 100 SHL (shift left by one via pass-cin).
  - 101..111 are illegal.
- The FSM has three states: IDLE, RUN, DONE. Reset puts it in IDLE.
- Reset values: in_ready=1, res_valid=0, res_data=0, res_err=0, busy=0, all slice_* outputs 0, counter 0, and operand registers 0.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready (cycle T), latch in_a, in_b and in_op, and clear res_data and res_err.
  - Legal op: go to RUN with counter=0.
  - Illegal op: go to DONE with res_err=1 and res_data=0. No slice activity occurs.
- RUN:
  - busy=1 and in_ready=0.
  - At counter k (cycle T+1+k): slice_a=a[k], slice_b=b[k], slice_opsel=op.
  - slice_cin = a[k-1] for SHL with k>0. For SHL with k=0, and for all other ops, slice_cin=0.
  - Capture slice_out into res_data[k] at the end of the cycle; slice_out is combinational within the cycle.
  - When k==WIDTH-1, go to DONE. Otherwise increment k.
- Latency: accept at T; res_valid rises at T+WIDTH+1. For an illegal op, res_valid rises at T+1.
- DONE:
  - res_valid=1, and res_data/res_err are held stable while res_ready=0.
  - On res_valid&res_ready, go to IDLE; in_ready=1 on the following cycle.
  - A new command is never accepted in the DONE cycle: no back-to-back overlap, and in_valid is ignored while in_ready=0.
- Outside RUN, slice_a, slice_b, slice_cin and slice_opsel are driven 0.
- Reset in any state, including mid-RUN: the in-flight command is discarded, no result is produced, and the next cycle shows reset values.
- Command inputs are sampled only at the accept edge. Changes to in_* after the accept edge have no effect.

Decomposition:
- Package lu_pkg:
  - op_t enum: LU_AND=3'b000, LU_OR, LU_XOR, LU_NOT, LU_SHL=3'b100.
  - state_t enum: S_IDLE, S_RUN, S_DONE.
  - function op_legal(op_t).
- The slice opsel encoding is defined only in lu_pkg, shared with the slice.
- One natural sub-module: lu_bitcnt, a CNTW-bit counter with clear, enable and a last flag (count==WIDTH-1).
- The bench instantiates the existing 1-bit logic slice to close the slice_* loop.

Test Plan:
- AND, a=8'hF0, b=8'h3C, accepted at T -> res_valid at T+9, res_data=8'h30, res_err=0, busy high T+1..T+8.
- XOR, a=8'hAA, b=8'hFF -> res_data=8'h55. NOT, a=8'h0F -> res_data=8'hF0. OR, a=8'h81, b=8'h18 -> res_data=8'h99.
- SHL, a=8'h81 -> res_data=8'h02; slice_cin=0 at k=0 and slice_cin=1 at k=1.
- Illegal op 3'b110, a=8'hFF -> res_valid at T+1, res_err=1, res_data=8'h00, no slice toggling.
- Backpressure: res_ready=0 for 5 cycles after res_valid -> res_data stable, in_ready=0, in_valid ignored. Then res_ready=1 -> in_ready=1 the next cycle.
- Reset asserted at k=3 of RUN -> next cycle in_ready=1, res_valid=0, busy=0, slice_* outputs 0, and no stale result appears later.
